// File: rtl/cr_kme_nibble_packer_pkg.sv
// Shared types and sizing helpers for the KME nibble packer.
package cr_kme_packer_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  // Width needed to express a nibble count of 0..out_w/NIB_W inclusive.
  function automatic int unsigned nib_cnt_w(input int unsigned out_w);
    return $clog2(out_w / NIB_W + 1);
  endfunction

endpackage

// File: rtl/cr_kme_nibble_packer.sv
// Packs 4-bit FIFO tokens LSN-first into OUT_W-bit words with flush support.
// Optional out_par port enabled by defining CR_KME_PACKER_PARITY_EN.
module cr_kme_nibble_packer
  import cr_kme_packer_pkg::*;
#(
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CW    = nib_cnt_w(OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NIB_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ack,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             flush_err
`ifdef CR_KME_PACKER_PARITY_EN
  ,
  output logic             out_par
`endif
);

  localparam int unsigned N = OUT_W / NIB_W;

  packer_state_e    state;
  logic [CW-1:0]    cnt;
  logic             ack;
  logic             full;
  logic [CW-1:0]    fill_cnt;
  logic [OUT_W-1:0] nxt_data;

  always_comb begin
    ack = 1'b0;
    if (!rst) begin
      ack = (state == FILL) ? in_valid : (in_valid && out_ready);
    end
  end

  assign in_ack   = ack;
  assign fill_cnt = cnt + CW'(ack);
  assign full     = (state == FILL) && ack && (cnt == CW'(N - 1));

  // out_data doubles as the accumulator; a handoff clears it so partial
  // words flushed later read zero in their unused slots.
  always_comb begin
    nxt_data = out_data;
    if (state == FILL) begin
      if (ack) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (CW'(k) == cnt) nxt_data[NIB_W*k +: NIB_W] = in_data;
        end
      end
    end else if (out_ready) begin
      nxt_data = '0;
      if (ack) nxt_data[NIB_W-1:0] = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      flush_err <= 1'b0;
    end else begin
      out_data  <= nxt_data;
      flush_err <= (state == HOLD) && flush;
      case (state)
        FILL: begin
          if (full) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= CW'(N);
            cnt       <= '0;
          end else if (flush && (fill_cnt != '0)) begin
            state     <= HOLD;
            out_valid <= 1'b1;
            out_count <= fill_cnt;
            cnt       <= '0;
          end else begin
            cnt <= fill_cnt;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            out_valid <= 1'b0;
            out_count <= '0;
            cnt       <= CW'(ack);
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CR_KME_PACKER_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) out_par <= 1'b0;
    else     out_par <= ^nxt_data;
  end
`endif

endmodule

// File: tb/tb_cr_kme_nibble_packer.sv
// Directed self-checking bench for cr_kme_nibble_packer at OUT_W=16.
module tb_cr_kme_nibble_packer;

  localparam int unsigned OUT_W = 16;
  localparam int unsigned CW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ack;
  logic             flush = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CW-1:0]    out_count;
  logic             flush_err;
`ifdef CR_KME_PACKER_PARITY_EN
  logic             out_par;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  cr_kme_nibble_packer #(.OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ack    (in_ack),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .flush_err (flush_err)
`ifdef CR_KME_PACKER_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one nibble (optionally with flush) for one edge, checking the pop strobe.
  task automatic feed(input logic [3:0] nib, input logic fl, input logic exp_ack);
    in_data  = nib;
    in_valid = 1'b1;
    flush    = fl;
    #1;
    check("in_ack", {31'd0, in_ack}, {31'd0, exp_ack});
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  logic [15:0] exp_word;

  initial begin
    // Reset: no pops while rst is high, registered outputs cleared.
    in_valid = 1'b1;
    tick();
    tick();
    check("rst_ack",   {31'd0, in_ack},    32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data",  {16'd0, out_data},  32'd0);
    check("rst_count", {29'd0, out_count}, 32'd0);
    check("rst_ferr",  {31'd0, flush_err}, 32'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    tick();

    // Basic word: 1,2,3,4.
    for (int i = 1; i <= 4; i++) feed(4'(i), 1'b0, 1'b1);
    check("a_valid", {31'd0, out_valid}, 32'd1);
    check("a_data",  {16'd0, out_data},  32'h4321);
    check("a_count", {29'd0, out_count}, 32'd4);
    drain();

    // Continuous stream 0..F with out_ready held high.
    exp_word = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) exp_word = '0;
      exp_word[4*(i%4) +: 4] = 4'(i);
      feed(4'(i), 1'b0, 1'b1);
      check("b_valid", {31'd0, out_valid}, (i % 4 == 3) ? 32'd1 : 32'd0);
      if (i % 4 == 3) check("b_data", {16'd0, out_data}, {16'd0, exp_word});
    end
    drain();

    // Partial word: 5,6 then 7 together with flush.
    feed(4'h5, 1'b0, 1'b1);
    feed(4'h6, 1'b0, 1'b1);
    feed(4'h7, 1'b1, 1'b1);
    check("c_valid", {31'd0, out_valid}, 32'd1);
    check("c_data",  {16'd0, out_data},  32'h0765);
    check("c_count", {29'd0, out_count}, 32'd3);
    drain();

    // Flush on an empty accumulator is ignored without error.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("e_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("e_ferr",  {31'd0, flush_err}, 32'd0);

    // Backpressure: full word held while input is pending; flush is dropped.
    out_ready = 1'b0;
    for (int i = 8; i <= 11; i++) feed(4'(i), 1'b0, 1'b1);
    check("d_valid", {31'd0, out_valid}, 32'd1);
    in_data  = 4'hC;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    check("d_ack_blk", {31'd0, in_ack}, 32'd0);
    tick();
    flush = 1'b0;
    check("d_ferr_hi", {31'd0, flush_err}, 32'd1);
    check("d_data",    {16'd0, out_data},  32'hBA98);
    tick();
    check("d_ferr_lo", {31'd0, flush_err}, 32'd0);
    check("d_data2",   {16'd0, out_data},  32'hBA98);
    check("d_count",   {29'd0, out_count}, 32'd4);
    out_ready = 1'b1;
    feed(4'hC, 1'b0, 1'b1);
    check("d_handoff", {31'd0, out_valid}, 32'd0);
    for (int i = 13; i <= 15; i++) feed(4'(i), 1'b0, 1'b1);
    check("d_data3",   {16'd0, out_data},  32'hFEDC);
    check("d_count3",  {29'd0, out_count}, 32'd4);
    drain();

    // Reset mid-word discards the two accepted nibbles.
    feed(4'h1, 1'b0, 1'b1);
    feed(4'h2, 1'b0, 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    #1;
    check("r_ack", {31'd0, in_ack}, 32'd0);
    tick();
    check("r_valid", {31'd0, out_valid}, 32'd0);
    check("r_count", {29'd0, out_count}, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 10; i <= 13; i++) feed(4'(i), 1'b0, 1'b1);
    check("r_data",  {16'd0, out_data},  32'hDCBA);
    check("r_count2", {29'd0, out_count}, 32'd4);
    drain();

    // Single nibble acked with flush: count 1, upper slots zero.
    feed(4'h7, 1'b1, 1'b1);
    check("s_data",  {16'd0, out_data},  32'h0007);
    check("s_count", {29'd0, out_count}, 32'd1);
`ifdef CR_KME_PACKER_PARITY_EN
    check("p_par7", {31'd0, out_par}, 32'd1);
`endif
    drain();
    feed(4'h3, 1'b1, 1'b1);
    check("s_data3", {16'd0, out_data}, 32'h0003);
`ifdef CR_KME_PACKER_PARITY_EN
    check("p_par3", {31'd0, out_par}, 32'd0);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
